// File: rtl/image_ring_writer_if.sv
// Pixel-stream, slot-control and BRAM-write bundle of the image ring writer.
// The master side is the producer/consumer and the slave side is the writer.
interface image_ring_writer_if #(
  parameter int PIXEL_SIZE     = 8,
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int PIXEL_PER_WORD = 1
);
  logic [PIXEL_SIZE-1:0]     pixel;
  logic                      pixel_valid;
  logic                      pixel_ready;
  logic                      flush;
  logic                      slot_release;
  logic [ADDR_WIDTH-1:0]     bram_addr;
  logic [DATA_WIDTH-1:0]     bram_data;
  logic [PIXEL_PER_WORD-1:0] w_enable;
  logic                      image_done;
  logic [2:0]                done_slot;
  logic [3:0]                slots_used;

  modport master (
    output pixel, pixel_valid, flush, slot_release,
    input  pixel_ready, bram_addr, bram_data, w_enable, image_done, done_slot, slots_used
  );

  modport slave (
    input  pixel, pixel_valid, flush, slot_release,
    output pixel_ready, bram_addr, bram_data, w_enable, image_done, done_slot, slots_used
  );
endinterface

// File: rtl/image_ring_writer.sv
// Packs incoming pixels into BRAM words and writes whole images into a ring
// of image slots. Slots are freed by the consumer; the producer is stalled
// while every slot is occupied.
module image_ring_writer #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    PIXEL_SIZE     = 8,
  parameter int                    PIXEL_PER_WORD = 1,
  parameter int                    IMAGE_PIXELS   = 784,
  parameter int                    NUM_SLOTS      = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  image_ring_writer_if.slave  bus
);
  localparam int WORDS_PER_IMAGE = (IMAGE_PIXELS + PIXEL_PER_WORD - 1) / PIXEL_PER_WORD;
  localparam int PCW = ($clog2(IMAGE_PIXELS) > 10) ? $clog2(IMAGE_PIXELS) : 10;
  localparam int LW  = (PIXEL_PER_WORD > 1) ? $clog2(PIXEL_PER_WORD) : 1;
  localparam logic [PCW-1:0]        LAST_PIXEL  = PCW'(IMAGE_PIXELS - 1);
  localparam logic [LW-1:0]         LAST_LANE   = LW'(PIXEL_PER_WORD - 1);
  localparam logic [2:0]            LAST_SLOT   = 3'(NUM_SLOTS - 1);
  localparam logic [3:0]            SLOTS_FULL  = 4'(NUM_SLOTS);
  localparam logic [ADDR_WIDTH-1:0] SLOT_STRIDE = ADDR_WIDTH'(WORDS_PER_IMAGE);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                    state_reg, state_next;
  logic [PCW-1:0]            pix_cnt_reg;
  logic [LW-1:0]             lane_cnt_reg;
  logic [2:0]                slot_reg;
  logic [ADDR_WIDTH-1:0]     slot_base_reg;
  logic [ADDR_WIDTH-1:0]     word_addr_reg;
  logic [DATA_WIDTH-1:0]     acc_reg;
  logic [3:0]                slots_used_reg, slots_used_next;
  logic [ADDR_WIDTH-1:0]     bram_addr_reg;
  logic [DATA_WIDTH-1:0]     bram_data_reg;
  logic [PIXEL_PER_WORD-1:0] w_enable_reg;
  logic                      image_done_reg;
  logic [2:0]                done_slot_reg;

  logic                      xfer, last_pixel, word_write, slot_inc, slot_dec;
  logic [DATA_WIDTH-1:0]     word_data;
  logic [PIXEL_PER_WORD-1:0] lane_mask;

  // A flush wins over a simultaneous handshake, so the pixel is dropped.
  assign xfer       = bus.pixel_valid && bus.pixel_ready && !bus.flush;
  assign last_pixel = (pix_cnt_reg == LAST_PIXEL);
  assign word_write = xfer && ((lane_cnt_reg == LAST_LANE) || last_pixel);
  assign slot_inc   = xfer && last_pixel;
  assign slot_dec   = bus.slot_release && (slots_used_reg != 4'd0);

  // Current pixel goes into its lane; lanes above it stay 0 because the
  // accumulator is cleared after every word and on flush.
  generate
    for (genvar gi = 0; gi < PIXEL_PER_WORD; gi++) begin : g_lane
      assign word_data[gi*PIXEL_SIZE +: PIXEL_SIZE] =
        (lane_cnt_reg == LW'(gi)) ? bus.pixel : acc_reg[gi*PIXEL_SIZE +: PIXEL_SIZE];
      assign lane_mask[gi] = (LW'(gi) <= lane_cnt_reg);
    end
  endgenerate

  // Occupied-slot count: completion and release in the same cycle cancel.
  always_comb begin
    slots_used_next = slots_used_reg;
    if (slot_inc && !slot_dec) begin
      slots_used_next = slots_used_reg + 4'd1;
    end else if (!slot_inc && slot_dec) begin
      slots_used_next = slots_used_reg - 4'd1;
    end
  end

  // Next state follows the slot count it will see in the coming cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FILL;
      FILL:    if (slots_used_next == SLOTS_FULL) state_next = FULL;
      FULL:    if (slots_used_next != SLOTS_FULL) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  // State and slot-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      slots_used_reg <= 4'd0;
    end else begin
      state_reg      <= state_next;
      slots_used_reg <= slots_used_next;
    end
  end

  // Pixel packing, address generation and the registered BRAM write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_reg    <= '0;
      lane_cnt_reg   <= '0;
      slot_reg       <= 3'd0;
      slot_base_reg  <= BASE_ADDR;
      word_addr_reg  <= BASE_ADDR;
      acc_reg        <= '0;
      bram_addr_reg  <= BASE_ADDR;
      bram_data_reg  <= '0;
      w_enable_reg   <= '0;
      image_done_reg <= 1'b0;
      done_slot_reg  <= 3'd0;
    end else begin
      w_enable_reg   <= '0;
      image_done_reg <= 1'b0;
      if (bus.flush) begin
        pix_cnt_reg   <= '0;
        lane_cnt_reg  <= '0;
        acc_reg       <= '0;
        word_addr_reg <= slot_base_reg;
      end else if (xfer) begin
        pix_cnt_reg <= last_pixel ? '0 : pix_cnt_reg + PCW'(1);
        if (word_write) begin
          lane_cnt_reg  <= '0;
          acc_reg       <= '0;
          bram_addr_reg <= word_addr_reg;
          bram_data_reg <= word_data;
          w_enable_reg  <= lane_mask;
          word_addr_reg <= word_addr_reg + ADDR_WIDTH'(1);
        end else begin
          lane_cnt_reg <= lane_cnt_reg + LW'(1);
          acc_reg      <= word_data;
        end
        // Image complete: report it and move to word 0 of the next slot.
        if (last_pixel) begin
          image_done_reg <= 1'b1;
          done_slot_reg  <= slot_reg;
          if (slot_reg == LAST_SLOT) begin
            slot_reg      <= 3'd0;
            slot_base_reg <= BASE_ADDR;
            word_addr_reg <= BASE_ADDR;
          end else begin
            slot_reg      <= slot_reg + 3'd1;
            slot_base_reg <= slot_base_reg + SLOT_STRIDE;
            word_addr_reg <= slot_base_reg + SLOT_STRIDE;
          end
        end
      end
    end
  end

  assign bus.pixel_ready = (state_reg == FILL);
  assign bus.bram_addr   = bram_addr_reg;
  assign bus.bram_data   = bram_data_reg;
  assign bus.w_enable    = w_enable_reg;
  assign bus.image_done  = image_done_reg;
  assign bus.done_slot   = done_slot_reg;
  assign bus.slots_used  = slots_used_reg;
endmodule

// File: tb/tb_image_ring_writer.sv
// Bench for image_ring_writer: a default-parameter instance checked every
// cycle against a slot/index model, plus a packed-word instance
// (4 pixels per word, 10-pixel images, 3 slots, base 0x20) with literal checks.
module tb_image_ring_writer;
  localparam int IMG = 784;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_on   = 0;

  image_ring_writer_if #(.PIXEL_SIZE(8), .ADDR_WIDTH(11), .DATA_WIDTH(8),  .PIXEL_PER_WORD(1)) bus_a ();
  image_ring_writer_if #(.PIXEL_SIZE(8), .ADDR_WIDTH(11), .DATA_WIDTH(32), .PIXEL_PER_WORD(4)) bus_b ();

  image_ring_writer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(11), .BASE_ADDR(11'h000), .PIXEL_SIZE(8),
    .PIXEL_PER_WORD(1), .IMAGE_PIXELS(IMG), .NUM_SLOTS(2)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  image_ring_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .BASE_ADDR(11'h020), .PIXEL_SIZE(8),
    .PIXEL_PER_WORD(4), .IMAGE_PIXELS(10), .NUM_SLOTS(3)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A: slot/pixel index bookkeeping, address = slot*IMG + index.
  int   m_idx, m_slot, m_used, m_edges, t_used;
  bit   m_ready, e_we, e_done, t_xfer, t_done;
  int   e_addr, e_data, e_dslot;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idx <= 0; m_slot <= 0; m_used <= 0; m_ready <= 0; m_edges <= 0;
      e_we <= 0; e_done <= 0; e_addr <= 0; e_data <= 0; e_dslot <= 0;
    end else begin
      t_xfer = bus_a.pixel_valid && m_ready && !bus_a.flush;
      t_done = t_xfer && (m_idx == IMG - 1);
      t_used = m_used + (t_done ? 1 : 0) - ((bus_a.slot_release && m_used > 0) ? 1 : 0);
      e_we   <= t_xfer;
      e_done <= t_done;
      if (t_xfer) begin
        e_addr <= m_slot * IMG + m_idx;
        e_data <= int'(bus_a.pixel);
      end
      if (t_done) begin
        e_dslot <= m_slot;
        m_slot  <= (m_slot + 1) % 2;
      end
      if (bus_a.flush) m_idx <= 0;
      else if (t_xfer) m_idx <= t_done ? 0 : m_idx + 1;
      m_used  <= t_used;
      m_ready <= (t_used < 2);
      if (m_edges < 2) m_edges <= m_edges + 1;
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (chk_on && reset_n === 1'b1) begin
      if (m_edges >= 2) chk("a_pixel_ready", bus_a.pixel_ready, m_ready);
      chk("a_w_enable", bus_a.w_enable, e_we);
      if (e_we) begin
        chk("a_bram_addr", bus_a.bram_addr, e_addr);
        chk("a_bram_data", bus_a.bram_data, e_data);
      end
      chk("a_image_done", bus_a.image_done, e_done);
      if (e_done) chk("a_done_slot", bus_a.done_slot, e_dslot);
      chk("a_slots_used", bus_a.slots_used, m_used);
    end
  end

  // Offer one pixel and hold it until accepted; returns at the negedge of the
  // cycle after the transfer, i.e. the cycle carrying the resulting write.
  task automatic send_a(input logic [7:0] v);
    int n = 0;
    bit r;
    bus_a.pixel = v;
    bus_a.pixel_valid = 1'b1;
    forever begin
      r = bus_a.pixel_ready;
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL a_send_timeout: pixel 0x%0h not accepted within 2000 cycles", v);
        break;
      end
    end
    bus_a.pixel_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    int n = 0;
    bit r;
    bus_b.pixel = v;
    bus_b.pixel_valid = 1'b1;
    forever begin
      r = bus_b.pixel_ready;
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL b_send_timeout: pixel 0x%0h not accepted within 2000 cycles", v);
        break;
      end
    end
    bus_b.pixel_valid = 1'b0;
  endtask

  task automatic chk_a_reset(input string tag);
    $display("check reset values (%s)", tag);
    chk({tag, "_ready"},      bus_a.pixel_ready, 0);
    chk({tag, "_w_enable"},   bus_a.w_enable, 0);
    chk({tag, "_bram_addr"},  bus_a.bram_addr, 0);
    chk({tag, "_bram_data"},  bus_a.bram_data, 0);
    chk({tag, "_image_done"}, bus_a.image_done, 0);
    chk({tag, "_done_slot"},  bus_a.done_slot, 0);
    chk({tag, "_slots_used"}, bus_a.slots_used, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b_data [3];
    logic [3:0]  b_en   [3];
    b_data = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'h0000A9A8};
    b_en   = '{4'b1111, 4'b1111, 4'b0011};

    reset_n = 1'b0;
    bus_a.pixel = '0; bus_a.pixel_valid = 0; bus_a.flush = 0; bus_a.slot_release = 0;
    bus_b.pixel = '0; bus_b.pixel_valid = 0; bus_b.flush = 0; bus_b.slot_release = 0;
    repeat (3) @(negedge clk);
    chk_a_reset("rst0");
    chk("rst0_b_addr", bus_b.bram_addr, 11'h020);
    reset_n = 1'b1;
    chk_on  = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("ready_after_reset_a", bus_a.pixel_ready, 1);
    chk("ready_after_reset_b", bus_b.pixel_ready, 1);

    // Packed instance: two 10-pixel images, words at 0x20.. then 0x23..
    for (int img = 0; img < 2; img++) begin
      for (int i = 0; i < 10; i++) begin
        send_b(8'hA0 + 8'(i));
        if (i == 3 || i == 7 || i == 9) begin
          $display("b write img %0d word %0d addr 0x%0h data 0x%0h en %b",
                   img, i / 4, bus_b.bram_addr, bus_b.bram_data, bus_b.w_enable);
          chk("b_w_enable", bus_b.w_enable, b_en[i/4]);
          chk("b_bram_addr", bus_b.bram_addr, 32'h20 + img * 3 + i / 4);
          chk("b_bram_data", bus_b.bram_data, b_data[i/4]);
        end else begin
          chk("b_no_write", bus_b.w_enable, 0);
        end
        chk("b_image_done", bus_b.image_done, (i == 9) ? 1 : 0);
      end
      chk("b_done_slot", bus_b.done_slot, img);
      chk("b_slots_used", bus_b.slots_used, img + 1);
    end

    // Images 1 and 2 fill both slots with back-to-back valid.
    for (int img = 0; img < 2; img++) begin
      for (int i = 0; i < IMG; i++) send_a(8'(i));
      $display("a image %0d done: addr %0d data 0x%0h slot %0d used %0d",
               img, bus_a.bram_addr, bus_a.bram_data, bus_a.done_slot, bus_a.slots_used);
      chk("a_last_done", bus_a.image_done, 1);
      chk("a_last_addr", bus_a.bram_addr, img == 0 ? 783 : 1567);
      chk("a_last_data", bus_a.bram_data, 8'h0F);
      chk("a_last_slot", bus_a.done_slot, img);
    end
    chk("a_full_ready", bus_a.pixel_ready, 0);
    chk("a_full_used", bus_a.slots_used, 2);

    // Offer image 3 while full, then free one slot.
    bus_a.pixel = 8'h00; bus_a.pixel_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("a_stall_no_write", bus_a.w_enable, 0);
    bus_a.slot_release = 1'b1;
    @(negedge clk);
    bus_a.slot_release = 1'b0;
    $display("a release while full: ready %0d used %0d", bus_a.pixel_ready, bus_a.slots_used);
    chk("a_release_ready", bus_a.pixel_ready, 1);
    chk("a_release_used", bus_a.slots_used, 1);
    for (int i = 0; i < IMG; i++) send_a(8'(i));
    chk("a_img3_addr", bus_a.bram_addr, 783);
    chk("a_img3_slot", bus_a.done_slot, 0);

    // Drain both slots, then one release too many.
    bus_a.slot_release = 1'b1;
    repeat (3) @(negedge clk);
    bus_a.slot_release = 1'b0;
    chk("a_release_at_zero", bus_a.slots_used, 0);

    // Flush after 100 pixels of image 4 (slot 1).
    for (int i = 0; i < 100; i++) send_a(8'(i));
    bus_a.pixel = 8'h55; bus_a.pixel_valid = 1'b1; bus_a.flush = 1'b1;
    @(negedge clk);
    bus_a.flush = 1'b0; bus_a.pixel_valid = 1'b0;
    $display("a flush: w_enable %0d used %0d", bus_a.w_enable, bus_a.slots_used);
    chk("a_flush_no_write", bus_a.w_enable, 0);
    for (int i = 0; i < IMG; i++) begin
      send_a(8'((i * 7 + 3) % 256));
      if (i == 0) begin
        chk("a_post_flush_addr", bus_a.bram_addr, 784);
        chk("a_post_flush_data", bus_a.bram_data, 3);
      end
    end
    chk("a_img4_addr", bus_a.bram_addr, 1567);
    chk("a_img4_data", bus_a.bram_data, 108);
    chk("a_img4_slot", bus_a.done_slot, 1);
    chk("a_img4_used", bus_a.slots_used, 1);

    // Image 5 (slot 0): release coincides with the last transfer.
    for (int i = 0; i < IMG - 1; i++) send_a(8'(i));
    bus_a.slot_release = 1'b1;
    send_a(8'(IMG - 1));
    bus_a.slot_release = 1'b0;
    $display("a release with done: done %0d slot %0d used %0d",
             bus_a.image_done, bus_a.done_slot, bus_a.slots_used);
    chk("a_coinc_done", bus_a.image_done, 1);
    chk("a_coinc_slot", bus_a.done_slot, 0);
    chk("a_coinc_used", bus_a.slots_used, 1);

    // Image 6 (slot 1): reset at pixel 500.
    for (int i = 0; i < 500; i++) send_a(8'(i));
    #2;
    reset_n = 1'b0;
    #1;
    chk_a_reset("rst_mid");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("a_ready_after_mid_reset", bus_a.pixel_ready, 1);
    send_a(8'h77);
    $display("a first write after reset: addr %0d data 0x%0h en %0d",
             bus_a.bram_addr, bus_a.bram_data, bus_a.w_enable);
    chk("a_restart_en", bus_a.w_enable, 1);
    chk("a_restart_addr", bus_a.bram_addr, 0);
    chk("a_restart_data", bus_a.bram_data, 8'h77);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
